// File: rtl/bsdeser.sv
// Bit-serial to parallel deserializer.
// Collects LEN serial bits (LSB first, framed by isync on bit 0) into a word
// and hands it to a valid/ready consumer through a separate output register,
// so the next frame can start shifting while the previous word waits.
// The serial side never stalls. A word that completes while the output
// register still holds an unconsumed word is dropped and flagged in overrun.
//
// Handshake: a word on data is consumed in every clk where valid && ready.
// valid stays high and data stays stable until that happens. After
// consumption data keeps its last value, and valid falls unless a new word
// completes in the same clk.
module bsdeser #(
    parameter int LEN = 22
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           is,
    input  logic           isync,
    input  logic           ready,
    output logic [LEN-1:0] data,
    output logic           valid,
    output logic           overrun,
    output logic [0:0]     state
);

    localparam int CW = $clog2(LEN);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [LEN-1:0] sreg;
    logic [CW-1:0]  cnt;
    logic [LEN-1:0] word;
    logic           complete;
    logic           accept;

    // The last bit is still on 'is' in the completing clk, so the finished
    // word is the shift register with its top bit taken straight from 'is'.
    always_comb begin
        word          = sreg;
        word[LEN-1]   = is;
    end

    // A word completes on the last bit of a frame. An isync there is a
    // resync instead, and the partial word is thrown away.
    assign complete = (state == SHIFT) && !isync && (cnt == CW'(LEN - 1));
    assign accept   = !valid || ready;

    // Serial side: framing state machine, bit counter and shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (isync) begin
                        sreg[0] <= is;
                        cnt     <= CW'(1);
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (isync) begin
                        sreg[0] <= is;
                        cnt     <= CW'(1);
                    end else begin
                        sreg[cnt] <= is;
                        if (cnt == CW'(LEN - 1)) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Parallel side: output register, valid flag and sticky overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else if (complete) begin
            if (accept) begin
                data  <= word;
                valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: doc/bsdeser.md
BSDESER -- requirements
Module: bsdeser

Interface
REQ-001: Parameter LEN, default 22, is the word width in bits; LEN >= 2 SHALL hold.
REQ-002: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003: clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004: is  input  1  bit-serial data stream, LSB first, one bit per clk.
REQ-005: isync  input  1  frame marker, high for exactly the clk in which bit 0 (LSB) of a word is on is.
REQ-006: data  output  LEN  last completed word, parallel, bit k = k-th serial bit.
REQ-007: valid  output  1  data holds an unconsumed word.
REQ-008: ready  input  1  consumer accepts data in any clk where valid && ready.
REQ-009: overrun  output  1  sticky flag, a completed word was dropped.

Function
REQ-010: Shift register sreg[LEN-1:0], bit counter cnt (0..LEN-1), state machine {IDLE, SHIFT}; output register data/valid kept separate from sreg so back-to-back frames are received with no gap.
REQ-011: IDLE: isync=0 -> is ignored, stay IDLE; isync=1 -> sreg[0]=is, cnt=1, go SHIFT.
REQ-012: SHIFT, isync=0: sreg[cnt]=is, cnt=cnt+1; if cnt was LEN-1 this bit completes the word -> go IDLE, cnt=0.
REQ-013: SHIFT, isync=1 (resync, including at cnt=LEN-1): partial word discarded, sreg[0]=is, cnt=1, stay SHIFT; no valid, no overrun.
REQ-014: Latency: isync with bit 0 in cycle t, last bit in cycle t+LEN-1 -> completed word on data with valid=1 in cycle t+LEN.
REQ-015: Completion transfers the word to data and sets valid=1 only if valid=0 or (valid && ready) in the completing cycle.
REQ-016: Completion with valid=1 && ready=0 -> data and valid unchanged, new word dropped, overrun=1.
REQ-017: valid && ready with no completion in the same cycle -> valid=0 next cycle; data SHALL keep its value (not cleared).
REQ-018: data SHALL not change while valid=1 && ready=0.
REQ-019: isync coinciding with a completion is impossible by REQ-013 (it is a resync); isync in the cycle after completion (back-to-back frames, period LEN) SHALL start the next word normally via IDLE.
REQ-020: overrun SHALL stay 1 until reset; it has no other clear.
REQ-021: ready SHALL have no effect on sreg, cnt or state; the serial side never stalls.

Reset
REQ-022: reset=1 -> state=IDLE, cnt=0, sreg=0, data=0, valid=0, overrun=0 at next edge, regardless of state or other inputs.
REQ-023: reset mid-frame discards the partial word; the first isync after reset deasserts starts a fresh word.
REQ-024: isync, is, ready sampled in a reset cycle SHALL be ignored.

Verification
REQ-025: LEN=22, ready=1, send 0x2AAAAA LSB first with isync at t=10 -> data=0x2AAAAA, valid=1 in cycle 32 only, overrun=0.
REQ-026: Back-to-back 0x000001 then 0x3FFFFF (isync at t and t+22), ready=1 -> valid at t+22 with 0x000001, at t+44 with 0x3FFFFF.
REQ-027: ready=0, two frames 0x123456 then 0x0ABCDE -> data stays 0x123456, overrun=1 from cycle after second completion; then ready=1 for one cycle -> valid=0.
REQ-028: Frame 0x111111, isync re-asserted at bit 10, then 22 bits of 0x222222 -> only 0x222222 delivered, overrun=0.
REQ-029: reset=1 for one cycle at bit 15 of a frame, then frame 0x155555 -> only 0x155555 delivered, all outputs 0 in cycle after reset.
REQ-030: Completion in same cycle as valid && ready on held word 0x000AAA, new word 0x000555 -> data=0x000555, valid=1, overrun=0.
